// File: rtl/r4_ifft_seq.sv
// Sequential 4-point radix-4 inverse DFT: load 4 bins, compute in one cycle, emit 4 samples.
// Optional IFFT_ROUND_EN: round half up before the divide-by-4 instead of flooring.
module r4_ifft_seq #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_last
);

  localparam int SW = DW + 2;

  typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

  state_t              r_state;
  logic [1:0]          r_idx;
  logic signed [DW-1:0] r_fr [4];
  logic signed [DW-1:0] r_fi [4];
  logic signed [DW-1:0] r_xr [1:3];
  logic signed [DW-1:0] r_xi [1:3];

  logic signed [SW-1:0] w_ar [4];
  logic signed [SW-1:0] w_ai [4];
  logic signed [SW-1:0] w_sr [4];
  logic signed [SW-1:0] w_si [4];
  logic signed [DW-1:0] w_xr [4];
  logic signed [DW-1:0] w_xi [4];

  // Sums are DW+2 wide so four full-scale terms never wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ar[k] = {{2{r_fr[k][DW-1]}}, r_fr[k]};
      w_ai[k] = {{2{r_fi[k][DW-1]}}, r_fi[k]};
    end
    w_sr[0] = w_ar[0] + w_ar[1] + w_ar[2] + w_ar[3];
    w_si[0] = w_ai[0] + w_ai[1] + w_ai[2] + w_ai[3];
    w_sr[1] = w_ar[0] - w_ai[1] - w_ar[2] + w_ai[3];
    w_si[1] = w_ai[0] + w_ar[1] - w_ai[2] - w_ar[3];
    w_sr[2] = w_ar[0] - w_ar[1] + w_ar[2] - w_ar[3];
    w_si[2] = w_ai[0] - w_ai[1] + w_ai[2] - w_ai[3];
    w_sr[3] = w_ar[0] + w_ai[1] - w_ar[2] - w_ai[3];
    w_si[3] = w_ai[0] - w_ar[1] - w_ai[2] + w_ar[3];
    for (int k = 0; k < 4; k++) begin
`ifdef IFFT_ROUND_EN
      w_xr[k] = DW'((w_sr[k] + SW'(2)) >>> 2);
      w_xi[k] = DW'((w_si[k] + SW'(2)) >>> 2);
`else
      w_xr[k] = DW'(w_sr[k] >>> 2);
      w_xi[k] = DW'(w_si[k] >>> 2);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      r_idx     <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      for (int k = 0; k < 4; k++) begin
        r_fr[k] <= '0;
        r_fi[k] <= '0;
      end
      for (int k = 1; k < 4; k++) begin
        r_xr[k] <= '0;
        r_xi[k] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && in_ready) begin
            r_fr[r_idx] <= in_r;
            r_fi[r_idx] <= in_i;
            r_idx       <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state  <= CALC;
              in_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          // x0 goes straight to the output register; x1..x3 wait in the result bank.
          for (int k = 1; k < 4; k++) begin
            r_xr[k] <= w_xr[k];
            r_xi[k] <= w_xi[k];
          end
          out_r     <= w_xr[0];
          out_i     <= w_xi[0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          r_idx     <= 2'd0;
          r_state   <= EMIT;
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (r_idx == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              r_idx     <= 2'd0;
              r_state   <= LOAD;
            end else begin
              out_r    <= r_xr[r_idx + 2'd1];
              out_i    <= r_xi[r_idx + 2'd1];
              out_last <= (r_idx == 2'd2);
              r_idx    <= r_idx + 2'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_r4_ifft_seq.sv
// Directed bench for r4_ifft_seq: hand-computed frames, latency, backpressure, mid-frame reset.
module tb_r4_ifft_seq;
  localparam int DW = 16;
`ifdef IFFT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r, in_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r, out_i;
  logic                 out_last;

  int n_tests = 0;
  int n_fail  = 0;

  r4_ifft_seq #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bin(input int r, input int i);
    @(negedge clk);
    in_valid = 1'b1;
    in_r = DW'(r);
    in_i = DW'(i);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    chk("in_ready_wait", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int fr [4], input int fi [4]);
    for (int k = 0; k < 4; k++) send_bin(fr[k], fi[k]);
  endtask

  task automatic recv(input string tag, input int er, input int ei, input int el);
    @(negedge clk);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk({tag, "_vld"},  int'(out_valid), 1);
    chk({tag, "_r"},    int'(out_r), er);
    chk({tag, "_i"},    int'(out_i), ei);
    chk({tag, "_last"}, int'(out_last), el);
    @(posedge clk);
    #1;
  endtask

  task automatic recv_const(input string tag, input int er, input int ei);
    for (int k = 0; k < 4; k++) recv(tag, er, ei, (k == 3) ? 1 : 0);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_vld"}, int'(out_valid), 0);
    chk({tag, "_idle_rdy"}, int'(in_ready), 1);
  endtask

  int c1r [4] = '{10, -2, -2, -2};
  int c1i [4] = '{0, 2, 0, -2};
  int zr  [4] = '{0, 0, 0, 0};

  initial begin
    int fr [4];
    int fi [4];
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_i", int'(out_i), 0);
    @(negedge clk) rst = 1'b0;

    // 1: basic frame plus latency
    send_frame(c1r, c1i);
    chk("t1_calc_vld", int'(out_valid), 0);
    chk("t1_calc_rdy", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("t1_emit_vld", int'(out_valid), 1);
    recv("t1_x0", 1, 0, 0);
    recv("t1_x1", 2, 0, 0);
    recv("t1_x2", 3, 0, 0);
    recv("t1_x3", 4, 0, 1);
    chk_idle("t1");

    // 2: DC real and DC imaginary
    fr = '{4, 0, 0, 0}; fi = zr;
    send_frame(fr, fi);
    recv_const("t2a", 1, 0);
    fr = zr; fi = '{4, 0, 0, 0};
    send_frame(fr, fi);
    recv_const("t2b", 0, 1);

    // 3: scaling / rounding boundary
    fr = '{2, 0, 0, 0}; fi = zr;
    send_frame(fr, fi);
    recv_const("t3a", RND, 0);
    fr = '{-1, 0, 0, 0};
    send_frame(fr, fi);
    recv_const("t3b", RND ? 0 : -1, 0);

    // 4: backpressure on x1 with in_valid pulses
    send_frame(c1r, c1i);
    recv("t4_x0", 1, 0, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_r = 16'sd99; in_i = 16'sd99;
      @(negedge clk);
      chk("t4_hold_vld", int'(out_valid), 1);
      chk("t4_hold_r", int'(out_r), 2);
      chk("t4_hold_i", int'(out_i), 0);
      chk("t4_hold_last", int'(out_last), 0);
      chk("t4_hold_rdy", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    recv("t4_x1", 2, 0, 0);
    recv("t4_x2", 3, 0, 0);
    recv("t4_x3", 4, 0, 1);
    chk_idle("t4");

    // 5: reset after two bins
    send_bin(7, 7);
    send_bin(5, -5);
    rst = 1'b1;
    #1;
    chk("t5_rst_rdy", int'(in_ready), 1);
    chk("t5_rst_vld", int'(out_valid), 0);
    chk("t5_rst_r", int'(out_r), 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_out", int'(out_valid), 0);
    end
    send_frame(c1r, c1i);
    recv("t5_x0", 1, 0, 0);
    recv("t5_x1", 2, 0, 0);
    recv("t5_x2", 3, 0, 0);
    recv("t5_x3", 4, 0, 1);

    // 6: full-scale bins
    fr = '{32767, 32767, 32767, 32767}; fi = fr;
    send_frame(fr, fi);
    recv("t6_x0", 32767, 32767, 0);
    recv("t6_x1", 0, 0, 0);
    recv("t6_x2", 0, 0, 0);
    recv("t6_x3", 0, 0, 1);
    chk_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
